// File: rtl/mc_control_if.sv
// Control-unit bus: opcode and memory handshake in, datapath controls and status out.
// The master side is the control FSM; the slave side is the datapath/instruction register.
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic             mem_ready;

    logic             IorD;
    logic             ALUSrcA;
    logic             IRWrite;
    logic             MemWrite;
    logic             PCWrite;
    logic             Branch;
    logic             BranchNE;
    logic             RegWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             ZeroExt;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSrc;

    logic [3:0]       state_o;
    logic             illegal;
    logic             retire;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  op, mem_ready,
        output IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, BranchNE,
               RegWrite, RegDst, MemtoReg, ZeroExt, ALUSrcB, ALUOp, PCSrc,
               state_o, illegal, retire, retired_count
    );

    modport slave (
        output op, mem_ready,
        input  IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, BranchNE,
               RegWrite, RegDst, MemtoReg, ZeroExt, ALUSrcB, ALUOp, PCSrc,
               state_o, illegal, retire, retired_count
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit with memory wait states, optional bne/j/logic-immediate
// support, sticky illegal-opcode trap and a retired-instruction counter.
module mc_control_fsm #(
    parameter bit MEM_HANDSHAKE     = 1'b1,
    parameter bit SUPPORT_BNE       = 1'b1,
    parameter bit SUPPORT_JUMP      = 1'b1,
    parameter bit SUPPORT_LOGIC_IMM = 1'b1,
    parameter int CNT_W             = 32
) (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMMEX    = 4'd9,
        S_IMMWB    = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q;
    state_t           state_d;
    logic [5:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;
    logic             rdy;
    logic             retire_c;
    logic             imm_zext;

    // Opcode dispatch out of DECODE; disabled optional opcodes trap like unknown ones.
    function automatic state_t decode_next(input logic [5:0] opc);
        state_t nxt;
        nxt = S_ILLEGAL;
        case (opc)
            OP_LW, OP_SW:         nxt = S_MEMADR;
            OP_RTYPE:             nxt = S_EXECUTE;
            OP_BEQ:               nxt = S_BRANCH;
            OP_BNE:               if (SUPPORT_BNE) nxt = S_BRANCH;
            OP_ADDI:              nxt = S_IMMEX;
            OP_ANDI, OP_ORI,
            OP_SLTI:              if (SUPPORT_LOGIC_IMM) nxt = S_IMMEX;
            OP_J:                 if (SUPPORT_JUMP) nxt = S_JUMP;
            default:              nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

    assign rdy      = bus.mem_ready | ~MEM_HANDSHAKE;
    assign imm_zext = (op_q == OP_ANDI) || (op_q == OP_ORI);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= bus.op;
            if (state_q == S_ILLEGAL)
                illegal_q <= 1'b1;
            if (retire_c)
                count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        retire_c     = 1'b0;
        bus.IorD     = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.Branch   = 1'b0;
        bus.BranchNE = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ZeroExt  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUOp    = 2'b00;
        bus.PCSrc    = 2'b00;

        case (state_q)
            S_FETCH: begin
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = rdy;
                bus.PCWrite = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                state_d     = decode_next(bus.op);
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.IorD = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = rdy;
                retire_c     = rdy;
                if (rdy) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = 2'b01;
                bus.PCSrc    = 2'b01;
                bus.Branch   = (op_q == OP_BEQ);
                bus.BranchNE = (op_q == OP_BNE);
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_IMMEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = (op_q == OP_ADDI) ? 2'b00 : 2'b11;
                bus.ZeroExt = imm_zext;
                state_d     = S_IMMWB;
            end
            S_IMMWB: begin
                bus.RegWrite = 1'b1;
                bus.ZeroExt  = imm_zext;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.PCSrc   = 2'b10;
                bus.PCWrite = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_ILLEGAL: begin
                state_d = S_ILLEGAL;
            end
            // Encodings 13-15 are unreachable but must still resolve to a known state.
            default: begin
                state_d = S_ILLEGAL;
            end
        endcase
    end

    assign bus.state_o       = state_q;
    assign bus.illegal       = illegal_q;
    assign bus.retire        = retire_c;
    assign bus.retired_count = count_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Parametrised multicycle MIPS control unit; successor to the fixed 11-state main decoder.
- Adds a memory-ready handshake (wait states), optional bne/j/logical-immediate support, illegal-opcode trapping, a retire pulse and a retired-instruction counter.
- Sits between the instruction register (op field) and the datapath muxes/enables.
- Feeds ALUOp to the existing ALU decoder.

Parameters:
- MEM_HANDSHAKE, 1: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready. 0 = mem_ready ignored, treated as 1.
- SUPPORT_BNE, 1: accept bne (000101).
- SUPPORT_JUMP, 1: accept j (000010).
- SUPPORT_LOGIC_IMM, 1: accept andi (001100), ori (001101), slti (001010).
- CNT_W, 32: width of retired_count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op  in  6  opcode from instruction register
- mem_ready  in  1  memory completes the current access this cycle
- IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, BranchNE, RegWrite, RegDst, MemtoReg, ZeroExt  out  1 each  datapath controls
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 signext imm, 11 imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct, 11 use op (ALU decoder decodes op)
- PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- state_o  out  4  current state encoding
- illegal  out  1  sticky illegal-opcode flag
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- retired_count  out  CNT_W  number of retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset is synchronous, active-high on clk; it is already decided as reset, with clock clk. Reset forces state = FETCH(0), op_q = 0, illegal = 0, retired_count = 0.
- Reset wins over every other event, including mid-wait and ILLEGAL.
- Outputs are Moore-decoded from the registered state. Exceptions: IRWrite, PCWrite and MemWrite are qualified by rdy (rdy = mem_ready | ~MEM_HANDSHAKE).
- Every output not listed for a state is 0. In the reset cycle, state = FETCH outputs.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, ILLEGAL 12.
- FETCH:
  - ALUSrcB=01, ALUOp=00, PCSrc=00, IorD=0, IRWrite=rdy, PCWrite=rdy.
  - Stay while !rdy, else go to DECODE.
- DECODE:
  - ALUSrcB=11, ALUOp=00.
  - op_q <= op (captured here only).
  - Next state by op:
    - lw/sw -> MEMADR
    - 000000 -> EXECUTE
    - beq, or bne if SUPPORT_BNE -> BRANCH
    - addi, or logic-imm if enabled -> IMMEX
    - j if SUPPORT_JUMP -> JUMP
    - anything else -> ILLEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. op_q==100011 -> MEMREAD, else MEMWRITE.
- MEMREAD: IorD=1. Stay while !rdy, else MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, retire=1. -> FETCH.
- MEMWRITE: IorD=1, MemWrite=rdy, retire=rdy. Stay while !rdy, else FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, retire=1. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=(op_q==000100), BranchNE=(op_q==000101), retire=1. -> FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. addi: ALUOp=00. andi/ori/slti: ALUOp=11, with ZeroExt=1 for andi/ori only. -> IMMWB.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1, ZeroExt held as in IMMEX, retire=1. -> FETCH.
- JUMP: PCSrc=10, PCWrite=1, retire=1. -> FETCH.
- ILLEGAL: illegal <= 1 (sticky). All enables 0. No exit except reset. retire never pulses.
- retired_count increments by 1 on each cycle with retire=1, wrapping from all-ones to 0.
- Latencies with rdy constantly 1: lw 5, sw 4, R-type 4, beq/bne 3, addi/andi/ori/slti 4, j 3 cycles.
- Each wait cycle adds 1 cycle; during waits, outputs other than the qualified enables are held stable.
- op changing after DECODE has no effect, because later decisions use op_q.
- No state is ever driven to x. Unused encodings 13–15 go to ILLEGAL.

Test Plan:
- lw (100011), mem_ready=1 -> state_o 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in cycle 5; retire pulses once; retired_count=1.
- sw (101011), mem_ready low for 3 cycles in MEMWRITE -> state_o stays 5 for 4 cycles. MemWrite=1 only in the 4th cycle, with retire on the same cycle.
- FETCH with mem_ready low for 2 cycles -> IRWrite=PCWrite=0 for 2 cycles, then 1 for one cycle; DECODE follows.
- bne (000101) with SUPPORT_BNE=1 -> BRANCH with BranchNE=1, Branch=0, PCSrc=01, ALUOp=01. With SUPPORT_BNE=0 -> state 12, illegal=1 and stays set for 10+ cycles.
- andi (001100) -> IMMEX/IMMWB with ALUOp=11 and ZeroExt=1. addi -> ALUOp=00, ZeroExt=0. j (000010) -> state 11, PCSrc=10, PCWrite=1.
- Reset asserted during MEMREAD wait or ILLEGAL -> next cycle state_o=0, illegal=0, retired_count=0, FETCH outputs. Also run 2^CNT_W retires with CNT_W=4 -> retired_count wraps 15→0.
